// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage MIPS pipeline: scoreboard, stall/flush, forwarding.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_scheduler #(
  parameter int NREG_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_d,
  input  logic             valid_d,
  input  logic             br_taken_e,
  input  logic             mem_busy,
  output logic             stall_o,
  output logic             bubble_e_o,
  output logic             flush_d_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

  typedef struct packed {
    logic              wr;
    logic [NREG_W-1:0] dst;
    logic              load;
  } sb_t;

  localparam sb_t SB_NOP = '0;

  state_t state;
  sb_t    sb_e, sb_m, sb_w, d_ent;

  logic [5:0]        op;
  logic [NREG_W-1:0] rs, rt, rd;
  logic              use_rs, use_rt;
  logic              lu;
  logic [1:0]        fa, fb;
  logic              unused_bits;

  assign op = instr_d[31:26];
  assign rs = instr_d[21 +: NREG_W];
  assign rt = instr_d[16 +: NREG_W];
  assign rd = instr_d[11 +: NREG_W];

  always_comb begin
    d_ent  = SB_NOP;
    use_rs = 1'b0;
    use_rt = 1'b0;
    if (valid_d) begin
      unique case (1'b1)
        op == 6'b000000: begin
          d_ent.wr  = rd != '0;
          d_ent.dst = rd;
          use_rs    = 1'b1;
          use_rt    = 1'b1;
        end
        op == 6'b100011: begin
          d_ent.wr   = rt != '0;
          d_ent.dst  = rt;
          d_ent.load = 1'b1;
          use_rs     = 1'b1;
        end
        op == 6'b101011,
        op == 6'b000100: begin
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // wr is only set for non-zero dst, so register 0 can never match
  function automatic logic hit(sb_t e, logic u, logic [NREG_W-1:0] s);
    return u && e.wr && (e.dst == s);
  endfunction

  function automatic logic [1:0] fsel(sb_t e, sb_t m, logic u,
                                      logic [NREG_W-1:0] s);
    if (hit(e, u, s) && !e.load) return 2'b01;
    if (hit(m, u, s))            return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    lu = sb_e.load && (hit(sb_e, use_rs, rs) || hit(sb_e, use_rt, rt));
    fa = fsel(sb_e, sb_m, use_rs, rs);
    fb = fsel(sb_e, sb_m, use_rt, rt);
  end

  assign flush_d_o  = !mem_busy && br_taken_e;
  assign bubble_e_o = !mem_busy && (br_taken_e || lu);
  assign stall_o    = mem_busy || (lu && !br_taken_e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      sb_e    <= SB_NOP;
      sb_m    <= SB_NOP;
      sb_w    <= SB_NOP;
      fwd_a_o <= 2'b00;
      fwd_b_o <= 2'b00;
    end else if (!mem_busy) begin
      sb_w    <= sb_m;
      sb_m    <= sb_e;
      sb_e    <= bubble_e_o ? SB_NOP : d_ent;
      fwd_a_o <= bubble_e_o ? 2'b00 : fa;
      fwd_b_o <= bubble_e_o ? 2'b00 : fb;
      if (br_taken_e)
        state <= FLUSH;
      else if (state == RUN && lu)
        state <= LDSTALL;
      else
        state <= RUN;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!mem_busy && lu && !br_taken_e && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_d_o && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

  // W entry is kept for completeness; distance 3 reads the register file
  assign unused_bits = ^{instr_d[10:0], sb_w};

endmodule

// File: tb/tb_hazard_scheduler.sv
// Randomized scoreboard bench for hazard_scheduler.
// Expected outputs come from a distance-based producer history model.
module tb_hazard_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_d = '0;
  logic        valid_d = 1'b0;
  logic        br_taken_e = 1'b0;
  logic        mem_busy = 1'b0;
  logic        stall_o, bubble_e_o, flush_d_o;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  hazard_scheduler dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
    .br_taken_e(br_taken_e), .mem_busy(mem_busy), .stall_o(stall_o),
    .bubble_e_o(bubble_e_o), .flush_d_o(flush_d_o), .fwd_a_o(fwd_a_o),
    .fwd_b_o(fwd_b_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, bu, fl, fa, fb, sc, fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // producer history, index 0 = instruction in E; dst -1 = no write
  int h_dst[3] = '{-1, -1, -1};
  int h_ld[3]  = '{0, 0, 0};
  int efa = 0, efb = 0, m_sc = 0, m_fc = 0;
  int last_stall = 0;

  function automatic logic [31:0] r_op(int d, int s, int t);
    logic [4:0] d5, s5, t5;
    d5 = d[4:0]; s5 = s[4:0]; t5 = t[4:0];
    return {6'b000000, s5, t5, d5, 11'h0};
  endfunction

  function automatic logic [31:0] i_op(logic [5:0] o, int s, int t);
    logic [4:0] s5, t5;
    s5 = s[4:0]; t5 = t[4:0];
    return {o, s5, t5, 16'h0004};
  endfunction

  function automatic int fsel(int s);
    if (s <= 0) return 0;
    if (h_dst[0] == s) return h_ld[0] ? 3 : 1;
    if (h_dst[1] == s) return 2;
    return 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic v, input logic br,
                      input logic busy, input logic rst);
    int   dst, ld, s0, s1, a, b, lu;
    exp_t e;
    @(negedge clk);
    instr_d = ins; valid_d = v; br_taken_e = br;
    mem_busy = busy; rst_n = rst;
    dst = -1; ld = 0; s0 = -1; s1 = -1;
    if (v) begin
      case (ins[31:26])
        6'b000000: begin dst = int'(ins[15:11]); s0 = int'(ins[25:21]); s1 = int'(ins[20:16]); end
        6'b100011: begin dst = int'(ins[20:16]); ld = 1; s0 = int'(ins[25:21]); end
        6'b101011, 6'b000100: begin s0 = int'(ins[25:21]); s1 = int'(ins[20:16]); end
        default: ;
      endcase
    end
    if (dst == 0) dst = -1;
    if (!rst) begin
      h_dst = '{-1, -1, -1}; h_ld = '{0, 0, 0};
      efa = 0; efb = 0; m_sc = 0; m_fc = 0;
      e.st = busy; e.bu = !busy && br; e.fl = !busy && br;
      e.fa = 0; e.fb = 0; e.sc = 0; e.fc = 0;
      exp_q.push_back(e);
      last_stall = e.st;
      return;
    end
    a = fsel(s0); b = fsel(s1);
    lu = (a == 3) || (b == 3);
    e.fa = efa; e.fb = efb;
    if (busy) begin
      e.st = 1; e.bu = 0; e.fl = 0;
    end else begin
      e.fl = br; e.bu = br || lu; e.st = lu && !br;
    end
    e.sc = m_sc; e.fc = m_fc;
`ifndef HAZARD_STATS_EN
    e.sc = 0; e.fc = 0;
`endif
    exp_q.push_back(e);
    last_stall = e.st;
    if (!busy) begin
      if (e.st && m_sc < 65535) m_sc++;
      if (e.fl && m_fc < 65535) m_fc++;
      h_dst[2] = h_dst[1]; h_ld[2] = h_ld[1];
      h_dst[1] = h_dst[0]; h_ld[1] = h_ld[0];
      h_dst[0] = e.bu ? -1 : dst;
      h_ld[0]  = e.bu ? 0 : ld;
      efa = e.bu ? 0 : a;
      efb = e.bu ? 0 : b;
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    int k = $urandom_range(0, 9);
    int d = $urandom_range(0, 4);
    int s = $urandom_range(0, 4);
    int t = $urandom_range(0, 4);
    case (k)
      0, 1, 2, 3: return r_op(d, s, t);
      4, 5:       return i_op(6'b100011, s, d);
      6:          return i_op(6'b101011, s, t);
      7:          return i_op(6'b000100, s, t);
      8:          return i_op(6'b001000, s, d);
      default:    return 32'h0;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", int'(stall_o), e.st);
        chk("bubble", int'(bubble_e_o), e.bu);
        chk("flush", int'(flush_d_o), e.fl);
        chk("fwd_a", int'(fwd_a_o), e.fa);
        chk("fwd_b", int'(fwd_b_o), e.fb);
        chk("stall_cnt", int'(stall_cnt_o), e.sc);
        chk("flush_cnt", int'(flush_cnt_o), e.fc);
      end
    end
  end

  initial begin : driver
    logic [31:0] cur;
    logic        cv;
    step(32'h0, 0, 0, 0, 0);
    step(32'h0, 0, 1, 0, 0);
    step(32'h0, 0, 0, 0, 1);
    // ALU -> ALU back-to-back
    step(r_op(3, 1, 2), 1, 0, 0, 1);
    step(r_op(5, 3, 4), 1, 0, 0, 1);
    step(32'h0, 1, 0, 0, 1);
    // load-use
    step(i_op(6'b100011, 1, 3), 1, 0, 0, 1);
    step(r_op(5, 2, 3), 1, 0, 0, 1);
    step(r_op(5, 2, 3), 1, 0, 0, 1);
    step(32'h0, 1, 0, 0, 1);
    // distance-2 branch source and $0 destination
    step(r_op(3, 1, 2), 1, 0, 0, 1);
    step(32'h0, 1, 0, 0, 1);
    step(i_op(6'b000100, 3, 4), 1, 0, 0, 1);
    step(r_op(0, 1, 2), 1, 0, 0, 1);
    step(r_op(5, 0, 0), 1, 0, 0, 1);
    step(32'h0, 1, 0, 0, 1);
    // branch beats load-use
    step(i_op(6'b100011, 1, 3), 1, 0, 0, 1);
    step(r_op(5, 3, 3), 1, 1, 0, 1);
    step(32'h0, 1, 0, 0, 1);
    // memory freeze across a load-use hazard
    step(i_op(6'b100011, 1, 3), 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(r_op(5, 2, 3), 1, 0, 1, 1);
    step(r_op(5, 2, 3), 1, 0, 0, 1);
    step(r_op(5, 2, 3), 1, 0, 0, 1);
    step(32'h0, 1, 0, 0, 1);
    // reset while stalled
    step(i_op(6'b100011, 1, 3), 1, 0, 0, 1);
    step(r_op(5, 3, 3), 1, 0, 0, 1);
    step(r_op(5, 3, 3), 1, 0, 0, 0);
    step(r_op(5, 3, 3), 1, 0, 0, 1);
    step(32'h0, 1, 0, 0, 1);
    // random traffic; D holds its instruction while stalled
    cur = rnd_instr(); cv = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        cur = rnd_instr();
        cv = ($urandom_range(0, 9) != 0);
      end
      step(cur, cv, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 99) != 0));
    end
    step(32'h0, 0, 0, 0, 1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #4;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
